// File: rtl/instr_encoder_loader.sv
// Field-level RV32I instruction encoder that streams packed words
// into consecutive instruction-memory addresses for program preload.
module instr_encoder_loader #(
   parameter int ADDR_WIDTH = 8,
   parameter int BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  finish,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [1:0]            in_fmt,
   input  logic [6:0]            in_opcode,
   input  logic [4:0]            in_rd,
   input  logic [4:0]            in_rs1,
   input  logic [4:0]            in_rs2,
   input  logic [2:0]            in_funct3,
   input  logic [6:0]            in_funct7,
   input  logic [31:0]           in_imm,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [31:0]           mem_wdata,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  busy,
   output logic                  done,
   output logic                  overflow,
   output logic                  fmt_err
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_LOAD  = 2'd1;
   localparam logic [1:0] S_WRITE = 2'd2;
   localparam logic [1:0] S_DONE  = 2'd3;

   localparam logic [1:0] F_I = 2'b00;
   localparam logic [1:0] F_S = 2'b01;
   localparam logic [1:0] F_B = 2'b10;
   localparam logic [1:0] F_R = 2'b11;

   localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDR);

   logic [1:0]            r_state;
   logic [ADDR_WIDTH:0]   r_count;
   logic [ADDR_WIDTH-1:0] r_addr;
   logic [31:0]           r_wdata;
   logic                  r_fin;
   logic                  r_ovf;
   logic                  r_ferr;

   logic                  w_hs;
   logic [31:0]           w_enc;
   logic [ADDR_WIDTH:0]   w_cnt_nxt;
   logic [ADDR_WIDTH-1:0] w_addr;

   assign w_hs      = in_valid & (r_state == S_LOAD);
   assign w_cnt_nxt = r_count + 1'b1;
   assign w_addr    = BASE + r_count[ADDR_WIDTH-1:0];

   always_comb begin
      w_enc = 32'd0;
      unique case (in_fmt)
         F_I: w_enc = {in_imm[11:0], in_rs1, in_funct3,
                       in_rd, in_opcode};
         F_S: w_enc = {in_imm[11:5], in_rs2, in_rs1,
                       in_funct3, in_imm[4:0], in_opcode};
         F_B: w_enc = {in_imm[12], in_imm[10:5], in_rs2,
                       in_rs1, in_funct3, in_imm[4:1],
                       in_imm[11], in_opcode};
         F_R: w_enc = {in_funct7, in_rs2, in_rs1,
                       in_funct3, in_rd, in_opcode};
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_IDLE;
         r_count <= '0;
         r_addr  <= BASE;
         r_wdata <= 32'd0;
         r_fin   <= 1'b0;
         r_ovf   <= 1'b0;
         r_ferr  <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_LOAD;
                  r_count <= '0;
                  r_ovf   <= 1'b0;
                  r_ferr  <= 1'b0;
                  r_fin   <= 1'b0;
               end
            end
            S_LOAD: begin
               if (w_hs) begin
                  r_wdata <= w_enc;
                  r_addr  <= w_addr;
                  r_fin   <= finish;
                  r_state <= S_WRITE;
                  // odd branch offsets are flagged but still written
                  if (in_fmt == F_B && in_imm[0])
                     r_ferr <= 1'b1;
               end else if (finish) begin
                  r_state <= S_DONE;
               end
            end
            S_WRITE: begin
               r_count <= w_cnt_nxt;
               if (r_fin || w_cnt_nxt[ADDR_WIDTH])
                  r_state <= S_DONE;
               else
                  r_state <= S_LOAD;
            end
            S_DONE: begin
               if (start) begin
                  r_state <= S_LOAD;
                  r_count <= '0;
                  r_ovf   <= 1'b0;
                  r_ferr  <= 1'b0;
                  r_fin   <= 1'b0;
               end else if (in_valid) begin
                  r_ovf <= 1'b1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // strobe decoded from state so an async reset drops it at once
   assign mem_we    = (r_state == S_WRITE);
   assign in_ready  = (r_state == S_LOAD);
   assign busy      = (r_state == S_LOAD) | (r_state == S_WRITE);
   assign done      = (r_state == S_DONE);
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign count     = r_count;
   assign overflow  = r_ovf;
   assign fmt_err   = r_ferr;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed bench: default-geometry loader plus a 4-word loader
// with wrapped base address, both driven from shared stimulus.
module tb_instr_encoder_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start, finish, in_valid;
   logic [1:0]  in_fmt;
   logic [6:0]  in_opcode, in_funct7;
   logic [4:0]  in_rd, in_rs1, in_rs2;
   logic [2:0]  in_funct3;
   logic [31:0] in_imm;

   logic        a_ready, a_we, a_busy, a_done, a_ovf, a_ferr;
   logic [7:0]  a_addr;
   logic [31:0] a_wdata;
   logic [8:0]  a_count;

   logic        b_ready, b_we, b_busy, b_done, b_ovf, b_ferr;
   logic [1:0]  b_addr;
   logic [31:0] b_wdata;
   logic [2:0]  b_count;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   instr_encoder_loader #(.ADDR_WIDTH(8), .BASE_ADDR(0)) u_a (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(a_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
      .in_funct7(in_funct7), .in_imm(in_imm),
      .mem_we(a_we), .mem_addr(a_addr), .mem_wdata(a_wdata),
      .count(a_count), .busy(a_busy), .done(a_done),
      .overflow(a_ovf), .fmt_err(a_ferr)
   );

   instr_encoder_loader #(.ADDR_WIDTH(2), .BASE_ADDR(3)) u_b (
      .clk(clk), .rst(rst), .start(start), .finish(finish),
      .in_valid(in_valid), .in_ready(b_ready),
      .in_fmt(in_fmt), .in_opcode(in_opcode), .in_rd(in_rd),
      .in_rs1(in_rs1), .in_rs2(in_rs2), .in_funct3(in_funct3),
      .in_funct7(in_funct7), .in_imm(in_imm),
      .mem_we(b_we), .mem_addr(b_addr), .mem_wdata(b_wdata),
      .count(b_count), .busy(b_busy), .done(b_done),
      .overflow(b_ovf), .fmt_err(b_ferr)
   );

   task automatic chk(input string tag, input logic [31:0] act,
                      input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // presents one bundle from a negedge; returns at the WRITE-phase negedge
   task automatic send(input logic [1:0] f, input logic [6:0] op,
                       input logic [4:0] rd, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm,
                       input logic fin);
      in_fmt = f; in_opcode = op; in_rd = rd; in_rs1 = rs1;
      in_rs2 = rs2; in_funct3 = f3; in_funct7 = f7; in_imm = imm;
      in_valid = 1'b1; finish = fin;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0; finish = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b0; start = 1'b0; finish = 1'b0; in_valid = 1'b0;
      in_fmt = 2'b00; in_opcode = 7'd0; in_rd = 5'd0; in_rs1 = 5'd0;
      in_rs2 = 5'd0; in_funct3 = 3'd0; in_funct7 = 7'd0;
      in_imm = 32'd0;

      @(negedge clk);
      chk("rst_we", a_we, 0);
      chk("rst_ready", a_ready, 0);
      chk("rst_busy", a_busy, 0);
      chk("rst_done", a_done, 0);
      chk("rst_count", a_count, 0);
      chk("rst_addr", a_addr, 0);
      chk("rst_wdata", a_wdata, 0);
      chk("rst_b_addr", b_addr, 3);
      rst = 1'b1;
      @(negedge clk);
      chk("idle_ready", a_ready, 0);

      pulse_start();
      chk("load_busy", a_busy, 1);
      chk("load_ready", a_ready, 1);

      send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
      chk("addi_we", a_we, 1);
      chk("addi_addr", a_addr, 0);
      chk("addi_word", a_wdata, 32'h00500093);
      chk("addi_ready", a_ready, 0);
      @(negedge clk);
      chk("addi_we_off", a_we, 0);
      chk("addi_count", a_count, 1);

      finish = 1'b1;
      @(negedge clk);
      finish = 1'b0;
      chk("fin_done", a_done, 1);
      chk("fin_nowrite", a_we, 0);
      chk("fin_count", a_count, 1);

      pulse_start();
      chk("restart_count", a_count, 0);
      send(2'b11, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
      chk("add_word", a_wdata, 32'h002081B3);
      chk("add_addr", a_addr, 0);
      chk("add_ready", a_ready, 0);
      @(negedge clk);
      send(2'b01, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8, 1'b0);
      chk("sw_word", a_wdata, 32'h0020A423);
      chk("sw_addr", a_addr, 1);
      chk("sw_we", a_we, 1);
      chk("sw_ready", a_ready, 0);
      @(negedge clk);
      chk("rs_count", a_count, 2);

      send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
           32'hFFFFFFFC, 1'b0);
      chk("beq_word", a_wdata, 32'hFE208EE3);
      chk("beq_ferr", a_ferr, 0);
      @(negedge clk);
      send(2'b10, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0,
           32'hFFFFFFFD, 1'b0);
      chk("beq_odd_word", a_wdata, 32'hFE208EE3);
      chk("beq_odd_addr", a_addr, 3);
      @(negedge clk);
      chk("beq_odd_ferr", a_ferr, 1);

      send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b1);
      chk("finhs_we", a_we, 1);
      chk("finhs_addr", a_addr, 4);
      chk("finhs_notdone", a_done, 0);
      @(negedge clk);
      chk("finhs_done", a_done, 1);
      chk("finhs_count", a_count, 5);

      pulse_start();
      chk("clr_ferr", a_ferr, 0);
      in_fmt = 2'b11; in_opcode = 7'h33; in_rd = 5'd3;
      in_rs1 = 5'd1; in_rs2 = 5'd2; in_funct3 = 3'd0;
      in_funct7 = 7'd0; in_valid = 1'b1;
      @(posedge clk);
      #2;
      chk("rstw_we_pre", a_we, 1);
      rst = 1'b0;
      #1;
      chk("rstw_we", a_we, 0);
      chk("rstw_wdata", a_wdata, 0);
      chk("rstw_addr", a_addr, 0);
      chk("rstw_count", a_count, 0);
      chk("rstw_busy", a_busy, 0);
      in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      in_valid = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("idle_nowrite", a_we, 0);
         chk("idle_ready2", a_ready, 0);
      end
      in_valid = 1'b0;
      chk("idle_count", a_count, 0);

      pulse_start();
      for (int i = 0; i < 4; i++) begin
         send(2'b00, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0,
              32'(i), 1'b0);
         chk("full_we", b_we, 1);
         chk("full_addr", b_addr, 32'((3 + i) % 4));
         @(negedge clk);
      end
      chk("full_done", b_done, 1);
      chk("full_count", b_count, 4);
      chk("full_ready", b_ready, 0);
      chk("full_ovf0", b_ovf, 0);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk("ovf_set", b_ovf, 1);
      chk("ovf_nowrite", b_we, 0);
      pulse_start();
      chk("ovf_clr", b_ovf, 0);
      chk("ovf_count", b_count, 0);
      chk("ovf_busy", b_busy, 1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/instr_encoder_loader.md
# instr_encoder_loader

- Sequential instruction encoder and program loader for the pipeline core.
- Inverse of the control-path decode: takes field-level RV32I instruction descriptions (format, opcode, rd, rs1, rs2, funct3, funct7, immediate) over a valid/ready handshake and packs each into a 32-bit machine word.
- Writes the words to consecutive addresses of the instruction memory write port.
- Used by bench and boot logic to preload programs before the core leaves reset.

## Interface

Parameters:
- ADDR_WIDTH, 8: instruction memory word-address width; depth = 2^ADDR_WIDTH words.
- BASE_ADDR, 0: word address of the first instruction written.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  single-cycle pulse that begins a load session.
- finish  input  1  end-of-program request.
- in_valid  input  1  field bundle valid.
- in_ready  output  1  encoder can accept a bundle.
- in_fmt  input  2  00 I, 01 S, 10 B, 11 R. The first three match the ImmSrc encoding.
- in_opcode  input  7  opcode field.
- in_rd, in_rs1, in_rs2  input  5 each  register fields.
- in_funct3  input  3  funct3 field.
- in_funct7  input  7  funct7 field; R only.
- in_imm  input  32  immediate, sign-extended, byte offset for B.
- mem_we  output  1  instruction memory write strobe.
- mem_addr  output  ADDR_WIDTH  write word address.
- mem_wdata  output  32  encoded instruction.
- count  output  ADDR_WIDTH+1  instructions written this session.
- busy  output  1  state is LOAD or WRITE.
- done  output  1  state is DONE.
- overflow  output  1  sticky: in_valid seen in DONE.
- fmt_err  output  1  sticky: B-format bundle with in_imm[0]=1.

## Operation

States: IDLE, LOAD, WRITE, DONE.

Transitions:
- IDLE: start -> LOAD. count, overflow and fmt_err are cleared.
- LOAD:
  - in_ready=1.
  - Handshake (in_valid & in_ready) captures the encoded word into a register -> WRITE.
  - finish without in_valid -> DONE.
  - finish together with a handshake: the bundle is written, then the FSM goes WRITE -> DONE.
- WRITE:
  - mem_we=1 for exactly one cycle, with mem_addr = (BASE_ADDR + count) mod 2^ADDR_WIDTH.
  - count increments.
  - If a finish is pending, or count reaches 2^ADDR_WIDTH -> DONE; otherwise -> LOAD.
- DONE:
  - in_ready=0.
  - in_valid sets overflow.
  - start -> LOAD, with the same clears as IDLE.
- start is ignored in LOAD and WRITE.
- finish is ignored outside LOAD.

Encoding (unused fields ignored; rd, rs1, rs2, funct3 are 5/5/5/3-bit fields):
- R: funct7 | rs2 | rs1 | funct3 | rd | opcode.
- I: imm[11:0] | rs1 | funct3 | rd | opcode.
- S: imm[11:5] | rs2 | rs1 | funct3 | imm[4:0] | opcode.
- B: imm[12] | imm[10:5] | rs2 | rs1 | funct3 | imm[4:1] | imm[11] | opcode.
  - imm[0] is dropped.
  - If imm[0]=1, fmt_err is set and the word is still written.

Width rules:
- Immediate bits above those listed are discarded; no range check.
- The address wraps modulo 2^ADDR_WIDTH when BASE_ADDR is nonzero.

## Timing

Reset (rst low, asynchronous):
- State IDLE.
- in_ready, mem_we, busy, done, overflow, fmt_err = 0.
- count = 0, mem_addr = BASE_ADDR, mem_wdata = 0.

Latency and throughput:
- A handshake at edge N gives mem_we=1 in the cycle after N, with mem_wdata equal to that bundle's encoding.
- Throughput is one instruction per 2 cycles.
- mem_wdata and mem_addr are registered and hold after WRITE.
- count updates at the edge that ends WRITE.

Full condition:
- After the write that takes count to 2^ADDR_WIDTH, the FSM enters DONE with no finish required.
- count then reads 2^ADDR_WIDTH.

Reset mid-operation:
- A reset asserted during WRITE aborts the write immediately; mem_we drops asynchronously.

## Test plan

- I: start, then addi x1,x0,5 (fmt 00, opcode 0x13, rd 1, rs1 0, funct3 0, imm 5) -> one mem_we pulse, mem_addr 0, mem_wdata 0x00500093, count 1.
- R and S back-to-back: add x3,x1,x2 (fmt 11, opcode 0x33), then sw x2,8(x1) (fmt 01, opcode 0x23, funct3 2) -> 0x002081B3 at address 0 and 0x0020A423 at address 1, two cycles apart; in_ready low during each WRITE.
- B: beq x1,x2,-4 (fmt 10, opcode 0x63, imm 0xFFFFFFFC) -> 0xFE208EE3, fmt_err 0. Repeat with imm 0xFFFFFFFD -> same word, fmt_err 1.
- Full and overflow: ADDR_WIDTH 2, BASE_ADDR 3, four bundles -> addresses 3,0,1,2; done 1, count 4; a fifth in_valid -> in_ready 0, overflow 1. Then start -> overflow 0, count 0.
- finish handling:
  - finish with a handshake in the same cycle -> that word is written, then done.
  - finish alone in LOAD -> done the next cycle, no write.
- Reset mid-WRITE:
  - rst low during WRITE -> mem_we 0 immediately; all outputs at reset values.
  - After release, state IDLE and start is required before any write.
